// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the writeback arbiter
package wb_arb_pkg;

    localparam int ROB_LEN   = 32;
    localparam int IDX_W     = $clog2(ROB_LEN);
    localparam int CNT_W     = 16;
    localparam int MAX_N_REQ = 8;

    typedef struct packed {
        logic [31:0]      data;
        logic [IDX_W-1:0] rob_idx;
    } wb_req_t;

    // Distance from the ROB head; wraps naturally in IDX_W bits.
    function automatic logic [IDX_W-1:0] rob_age(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W-1:0] head);
        return idx - head;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// rtl/wb_arbiter_rr.sv - round-robin arbiter, priority starting at rr_ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         eligible,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int ID_W = $clog2(N);

    always_comb begin
        int  idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && eligible[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - shares the ROB writeback port among N_REQ result streams
// WB_ARB_AGE_PRIO_EN selects oldest-first arbitration instead of round-robin.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0][31:0]       req_data,
    input  logic [N_REQ-1:0][IDX_W-1:0]  req_rob_idx,
    input  logic                         mispredict,
    input  logic [ROB_LEN-1:0]           flush_mask,
    input  logic                         stall,
    input  logic [IDX_W-1:0]             rob_head,
    output logic                         WB_valid,
    output logic [31:0]                  WB_data,
    output logic [IDX_W-1:0]             WB_rob_idx,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic [CNT_W-1:0]             squash_cnt
);

    localparam int ID_W = $clog2(N_REQ);

    wb_req_t            bufs [N_REQ];
    logic [N_REQ-1:0]   buf_valid;
    logic [N_REQ-1:0]   buf_flushed;
    logic [N_REQ-1:0]   in_flushed;
    logic [N_REQ-1:0]   accept;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    win_id;
    logic               any_grant;
    logic               wb_valid_q;
    wb_req_t            wb_q;
    logic [ID_W-1:0]    grant_q;
    logic               wb_flushed;
    logic [4:0]         sq_inc;
    logic [CNT_W:0]     sq_sum;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            buf_flushed[i] = mispredict && flush_mask[bufs[i].rob_idx];
            in_flushed[i]  = mispredict && flush_mask[req_rob_idx[i]];
            eligible[i]    = buf_valid[i] && !stall && !buf_flushed[i];
        end
    end

    assign req_ready = ~buf_valid | grant;
    assign accept    = req_valid & req_ready;
    assign any_grant = |grant;

`ifndef WB_ARB_AGE_PRIO_EN
    logic [ID_W-1:0] rr_ptr;
    logic            unused_rob_head;

    assign unused_rob_head = ^rob_head;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .grant_id (win_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
        end
    end
`else
    always_comb begin
        logic [IDX_W-1:0] best_age;
        logic [IDX_W-1:0] age;
        logic             found;
        grant    = '0;
        win_id   = '0;
        best_age = '1;
        found    = 1'b0;
        // Strict less-than keeps ties on the lower requester index.
        for (int i = 0; i < N_REQ; i++) begin
            age = rob_age(bufs[i].rob_idx, rob_head);
            if (eligible[i] && (!found || age < best_age)) begin
                found    = 1'b1;
                best_age = age;
                win_id   = ID_W'(i);
            end
        end
        if (found) begin
            grant[win_id] = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                bufs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept[i] && !in_flushed[i]) begin
                    buf_valid[i] <= 1'b1;
                    bufs[i]      <= '{data: req_data[i], rob_idx: req_rob_idx[i]};
                end else if (grant[i] || buf_flushed[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign wb_flushed = wb_valid_q && mispredict && flush_mask[wb_q.rob_idx];

    // Every result that dies this cycle: at the input, in a buffer, or in the WB stage.
    always_comb begin
        sq_inc = 5'(wb_flushed);
        for (int i = 0; i < N_REQ; i++) begin
            sq_inc = sq_inc + 5'(accept[i] && in_flushed[i])
                            + 5'(buf_valid[i] && buf_flushed[i]);
        end
        sq_sum = {1'b0, squash_cnt} + (CNT_W + 1)'(sq_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
            grant_q    <= '0;
            squash_cnt <= '0;
        end else begin
            wb_valid_q <= any_grant;
            if (any_grant) begin
                wb_q    <= bufs[win_id];
                grant_q <= win_id;
            end
            squash_cnt <= sq_sum[CNT_W] ? '1 : sq_sum[CNT_W-1:0];
        end
    end

    assign WB_valid   = wb_valid_q && !wb_flushed;
    assign WB_data    = wb_q.data;
    assign WB_rob_idx = wb_q.rob_idx;
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter (WB_ARB_AGE_PRIO_EN selects age tests)
module tb_wb_arbiter;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic [4:0]  idx;
    } beat_t;

    typedef struct packed {
        logic [3:0]      mask;
        logic [2:0]      n;
        logic [3:0][1:0] ord;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][31:0] req_data;
    logic [3:0][4:0]  req_rob_idx;
    logic             mispredict;
    logic [31:0]      flush_mask;
    logic             stall;
    logic [4:0]       rob_head;
    logic             WB_valid;
    logic [31:0]      WB_data;
    logic [4:0]       WB_rob_idx;
    logic [1:0]       grant_id;
    logic [15:0]      squash_cnt;

    int    checks = 0;
    int    fails  = 0;
    beat_t sb[$];
    vec_t  tbl[7];

    wb_arbiter #(.N_REQ(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_rob_idx (req_rob_idx),
        .mispredict  (mispredict),
        .flush_mask  (flush_mask),
        .stall       (stall),
        .rob_head    (rob_head),
        .WB_valid    (WB_valid),
        .WB_data     (WB_data),
        .WB_rob_idx  (WB_rob_idx),
        .grant_id    (grant_id),
        .squash_cnt  (squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic vec_t mk(input logic [3:0] m, input logic [2:0] n,
                                input logic [1:0] o0, input logic [1:0] o1,
                                input logic [1:0] o2, input logic [1:0] o3);
        return '{mask: m, n: n, ord: {o3, o2, o1, o0}};
    endfunction

    function automatic logic [31:0] vdata(input int v, input int i);
        return 32'hA500_0000 | 32'(v << 8) | 32'(i);
    endfunction

    function automatic logic [4:0] vidx(input int v, input int i);
        return 5'(v * 4 + i + 1);
    endfunction

    // Scoreboard: every visible WB beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && WB_valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL wb_unexpected: got id=%0d data=%0h idx=%0d, expected no beat",
                         grant_id, WB_data, WB_rob_idx);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("wb_beat", 64'({grant_id, WB_data, WB_rob_idx}), 64'(e));
            end
        end
    end

    task automatic load(input logic [3:0] m);
        req_valid = m;
        tick();
        req_valid = '0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; req_rob_idx = '0;
        mispredict = 1'b0; flush_mask = '0; stall = 1'b0; rob_head = '0;

        tbl[0] = mk(4'b1000, 3'd1, 2'd3, 2'd0, 2'd0, 2'd0);
        tbl[1] = mk(4'b0101, 3'd2, 2'd0, 2'd2, 2'd0, 2'd0);
        tbl[2] = mk(4'b0110, 3'd2, 2'd1, 2'd2, 2'd0, 2'd0);
        tbl[3] = mk(4'b1001, 3'd2, 2'd3, 2'd0, 2'd0, 2'd0);
        tbl[4] = mk(4'b1010, 3'd2, 2'd1, 2'd3, 2'd0, 2'd0);
        tbl[5] = mk(4'b0111, 3'd3, 2'd0, 2'd1, 2'd2, 2'd0);
        tbl[6] = mk(4'b1000, 3'd1, 2'd3, 2'd0, 2'd0, 2'd0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_ready", 64'(req_ready), 64'hF);
        chk("reset_wb_valid", 64'(WB_valid), 64'd0);
        chk("reset_wb_data", 64'(WB_data), 64'd0);
        chk("reset_grant_id", 64'(grant_id), 64'd0);
        chk("reset_squash", 64'(squash_cnt), 64'd0);

        // Single requester latency: accept edge, arbitrate, then WB.
        req_data[0] = 32'hDEAD_BEEF; req_rob_idx[0] = 5'd5;
        sb.push_back('{id: 2'd0, data: 32'hDEAD_BEEF, idx: 5'd5});
        load(4'b0001);
        chk("lat_cycle1_valid", 64'(WB_valid), 64'd0);
        tick();
        chk("lat_cycle2_valid", 64'(WB_valid), 64'd1);
        chk("lat_cycle2_beat", 64'({grant_id, WB_data, WB_rob_idx}),
            64'({2'd0, 32'hDEAD_BEEF, 5'd5}));
        drain();

`ifndef WB_ARB_AGE_PRIO_EN
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 4; i++) begin
                req_data[i]    = vdata(v, i);
                req_rob_idx[i] = vidx(v, i);
            end
            for (int k = 0; k < int'(tbl[v].n); k++) begin
                int g;
                g = int'(tbl[v].ord[k]);
                sb.push_back('{id: 2'(g), data: vdata(v, g), idx: vidx(v, g)});
            end
            load(tbl[v].mask);
            drain();
        end

        // Full contention from rr_ptr=0; each requester is ready in its grant cycle.
        for (int i = 0; i < 4; i++) begin
            req_data[i] = 32'hC000_0000 + 32'(i); req_rob_idx[i] = 5'(20 + i);
            sb.push_back('{id: 2'(i), data: 32'hC000_0000 + 32'(i), idx: 5'(20 + i)});
        end
        load(4'b1111);
        for (int k = 0; k < 4; k++) begin
            chk("contend_ready", 64'(req_ready), 64'((1 << (k + 1)) - 1));
            tick();
        end
        drain();
        // rr_ptr back at 0: requester 0 must beat requester 3.
        sb.push_back('{id: 2'd0, data: 32'hC000_0000, idx: 5'd20});
        sb.push_back('{id: 2'd3, data: 32'hC000_0003, idx: 5'd23});
        load(4'b1001);
        drain();
`endif

        // Flush of a buffered result while another survives.
        stall = 1'b1;
        req_data[1] = 32'h1111_0003; req_rob_idx[1] = 5'd3;
        req_data[2] = 32'h2222_0009; req_rob_idx[2] = 5'd9;
        load(4'b0110);
        mispredict = 1'b1; flush_mask = 32'h1 << 9;
        #1 chk("flush_ready", 64'(req_ready), 64'b1001);
        tick();
        mispredict = 1'b0; flush_mask = '0;
        chk("flush_squash", 64'(squash_cnt), 64'd1);
        sb.push_back('{id: 2'd1, data: 32'h1111_0003, idx: 5'd3});
        stall = 1'b0;
        drain();
        repeat (2) tick();

        // Result squashed in its accept cycle.
        req_data[0] = 32'h4444_0007; req_rob_idx[0] = 5'd7;
        mispredict = 1'b1; flush_mask = 32'h1 << 7;
        load(4'b0001);
        mispredict = 1'b0; flush_mask = '0;
        chk("accept_flush_squash", 64'(squash_cnt), 64'd2);
        chk("accept_flush_ready", 64'(req_ready), 64'hF);
        repeat (3) tick();

        // Result squashed while sitting in the WB stage.
        req_data[3] = 32'h3333_000C; req_rob_idx[3] = 5'd12;
        load(4'b1000);
        tick();
        mispredict = 1'b1; flush_mask = 32'h1 << 12;
        #1 chk("wb_flush_gated", 64'(WB_valid), 64'd0);
        tick();
        mispredict = 1'b0; flush_mask = '0;
        chk("wb_flush_squash", 64'(squash_cnt), 64'd3);
        repeat (2) tick();

`ifndef WB_ARB_AGE_PRIO_EN
        // Stall: results held, then both emerge right after stall drops.
        stall = 1'b1;
        req_data[0] = 32'h5555_0000; req_rob_idx[0] = 5'd14;
        req_data[2] = 32'h5555_0002; req_rob_idx[2] = 5'd16;
        req_valid = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            chk("stall_wb_valid", 64'(WB_valid), 64'd0);
            tick();
            req_valid = '0;
            chk("stall_ready", 64'(req_ready), 64'b1010);
        end
        sb.push_back('{id: 2'd0, data: 32'h5555_0000, idx: 5'd14});
        sb.push_back('{id: 2'd2, data: 32'h5555_0002, idx: 5'd16});
        stall = 1'b0;
        repeat (3) tick();
        chk("stall_release_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset in the middle of a burst (rr_ptr=3 here).
        for (int i = 0; i < 4; i++) begin
            req_data[i] = 32'h6666_0000 + 32'(i); req_rob_idx[i] = 5'(24 + i);
        end
        sb.push_back('{id: 2'd3, data: 32'h6666_0003, idx: 5'd27});
        load(4'b1111);
        tick();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_wb_valid", 64'(WB_valid), 64'd0);
        chk("arst_ready", 64'(req_ready), 64'hF);
        chk("arst_squash", 64'(squash_cnt), 64'd0);
        chk("arst_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
`else
        // Oldest-first: age(31)=1 beats age(1)=3 with rob_head=30.
        rob_head = 5'd30;
        stall = 1'b1;
        req_data[0] = 32'h7777_0001; req_rob_idx[0] = 5'd1;
        req_data[3] = 32'h7777_001F; req_rob_idx[3] = 5'd31;
        load(4'b1001);
        sb.push_back('{id: 2'd3, data: 32'h7777_001F, idx: 5'd31});
        sb.push_back('{id: 2'd0, data: 32'h7777_0001, idx: 5'd1});
        stall = 1'b0;
        drain();
        repeat (2) tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the single ROB writeback port (WB_valid / WB_data / WB_rob_idx) among N_REQ functional-unit result streams. Each requester owns a one-entry holding buffer. A round-robin (or optionally age-priority) arbiter selects one buffered result per cycle into a registered writeback stage. Results belonging to flushed ROB entries are discarded, and no grants are issued while ROB recovery is in progress.

## Interface
- N_REQ, 4, number of result requesters (2..8)
- ROB_LEN, 32, ROB depth; IDX_W = $clog2(ROB_LEN)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  per-requester result valid
- req_ready  out  N_REQ  per-requester buffer can accept
- req_data  in  N_REQ×32  result data
- req_rob_idx  in  N_REQ×IDX_W  ROB index of result
- mispredict  in  1  flush event this cycle
- flush_mask  in  ROB_LEN  ROB entries squashed by this mispredict (valid only when mispredict=1)
- stall  in  1  ROB in recovery; suppresses grants
- rob_head  in  IDX_W  ROB head pointer (used only with WB_ARB_AGE_PRIO_EN)
- WB_valid  out  1  registered writeback valid
- WB_data  out  32  registered writeback data
- WB_rob_idx  out  IDX_W  registered writeback index
- grant_id  out  $clog2(N_REQ)  requester that produced the current WB beat
- squash_cnt  out  16  saturating count of discarded results

## Operation
- Buffer i: buf_valid[i], buf_data[i], buf_idx[i].
- req_ready[i] = !buf_valid[i] || grant[i]; the result is purely from register state plus grant, and does not depend on req_valid.
- Handshake: accept when req_valid[i] && req_ready[i]; the buffer loads at the edge.
- If mispredict=1 and flush_mask[req_rob_idx[i]]=1 in the accept cycle: the handshake completes, the result is dropped, and squash_cnt increments.
- Eligible[i] = buf_valid[i] && !stall && !(mispredict && flush_mask[buf_idx[i]]).
- Grant (default): round-robin. Priority starts at rr_ptr, where rr_ptr = last grant + 1 mod N_REQ. rr_ptr is unchanged when there is no grant.
- Granted buffer clears at the edge unless refilled the same cycle (simultaneous drain and fill is legal).
- Buffers with flushed idx clear on a mispredict edge. Each increments squash_cnt; multiple squashes in one cycle add their popcount.
- WB stage: loads the winner, or WB_valid=0 when no grant. It is a one-cycle pulse per grant.
- WB_valid output is gated combinationally: low when mispredict && flush_mask[WB_rob_idx]. That beat also counts as squashed.
- squash_cnt saturates at 16'hFFFF.
- During stall: buffers still accept (up to one each); no grants; rr_ptr frozen.

## Timing
- Reset (async): all buf_valid=0, rr_ptr=0, WB_valid=0, WB_data=0, WB_rob_idx=0, grant_id=0, squash_cnt=0. req_ready therefore = all ones.
- Latency: accepted at edge T, arbitrated in cycle T+1, WB_valid high in cycle T+2 (minimum 2 cycles).
- Throughput: 1 result/cycle aggregate; 1 result/cycle per requester when uncontended (drain+fill).
- Reset mid-operation discards all buffered and in-flight results; no partial beats.
- rob_idx wrap-around: no ordering assumed in round-robin mode.

## Configuration
- WB_ARB_AGE_PRIO_EN defined: winner is the eligible buffer with smallest age = (buf_idx − rob_head) mod ROB_LEN (IDX_W-bit wrap subtraction). Ties go to the lower requester index. rr_ptr is not used.
- Undefined: round-robin as above; rob_head is ignored.

## Structure
- Shared package wb_arb_pkg: typedef wb_req_t {data[31:0], rob_idx[IDX_W-1:0]}; localparams for counter width (16) and max N_REQ.
- Sub-module rr_arbiter (N param): inputs eligible vector and rr_ptr; outputs one-hot grant and encoded id. It is instantiated only when WB_ARB_AGE_PRIO_EN is undefined.

## Test plan
- Single requester: req0 valid with data=32'hDEAD_BEEF, idx=5 at cycle 0. Required: WB_valid=1, WB_data=DEAD_BEEF, WB_rob_idx=5, grant_id=0 in cycle 2.
- Contention: all 4 buffers full, no stall. Required: grant order 0,1,2,3 over four consecutive cycles, then rr_ptr=0; req_ready[i] high in each requester's grant cycle.
- Flush: buffers hold idx 3 (req1) and 9 (req2); mispredict with flush_mask bit 9 set. Required: req2 buffer cleared, never written back; squash_cnt=1; idx 3 still written back.
- Stall: stall=1 for 5 cycles with 2 buffered results. Required: WB_valid=0 throughout and req_ready=0 for full buffers; both results emerge in the 2 cycles after stall drops.
- Age mode (macro defined): rob_head=30, ROB_LEN=32; buffers idx 1 (req0) and 31 (req3). Required: req3 granted first (age 1 vs 3).
- Async reset asserted mid-burst. Required: WB_valid=0 immediately, all req_ready=1, squash_cnt=0.
